del_token_responder: RTL
========================

Name: del_token_responder

Overview:
- Synchronous responder at the output end of an asynchronous delay/request chain (telescope/DELn stages).
- Receives a two-phase (toggle) bundled-data request, buffers the token in a small FIFO, and returns a two-phase acknowledge.
- Presents buffered tokens to clocked logic on a valid/ready stream. Closes the loop so the async pipeline can issue its next token.

Parameters:
- DATA_W, 8, width of bundled data carried with each request.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flops in the in_R synchronizer; minimum 2.
- CNT_W, 16, width of the accepted-token counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_R  in  1  two-phase request from async chain; each toggle is one token.
- in_data  in  DATA_W  bundled data; stable from the in_R toggle until the matching out_A toggle.
- out_A  out  1  two-phase acknowledge; toggles once per accepted token.
- m_valid  out  1  FIFO head holds a token.
- m_ready  in  1  consumer accepts the head this cycle.
- m_data  out  DATA_W  FIFO head data.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- stall  out  1  request pending but FIFO full.
- tok_cnt  out  CNT_W  accepted-token count; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronizer flops, ack phase, read/write pointers, level, tok_cnt and stall clear to 0.
  - out_A=0 and m_valid=0. m_data is don't-care while m_valid=0.
  - Sender must also return its in_R to 0 under system reset.
- Synchronizer: in_R passes through SYNC_STAGES flops to give req_s. in_data is not synchronized; bundled-data timing guarantees stability.
- FSM, two states:
  - IDLE: req_s == ack. No pending token.
  - PEND: req_s != ack. A token is pending.
- Capture, in PEND:
  - If FIFO not full, or a pop occurs the same cycle: write in_data at wptr, increment wptr, toggle ack, increment tok_cnt (saturating). Go to IDLE on the next cycle, since req_s now equals ack.
  - Otherwise stay in PEND and assert stall=1 (registered).
- out_A is the registered ack phase.
- Latency: in_R toggle to out_A toggle is SYNC_STAGES+1 clk edges when there is space. This is the minimum. Any additional in_R toggle before out_A toggles is a protocol violation.
- Pop: when m_valid && m_ready, increment rptr. m_data equals mem[rptr]; it is combinational from registered storage.
- Simultaneous push and pop:
  - level is unchanged.
  - When full, a pop frees the slot for the same-cycle push.
  - When empty, the pushed token becomes visible next cycle. No fall-through.
- Pointers are log2(DEPTH)+1 bits wide. Wrap-around is modulo 2*DEPTH.
  - full when the MSBs differ and the lower bits are equal.
  - empty when the pointers are equal.
- level = wptr - rptr, never exceeding DEPTH.
- m_ready while m_valid=0 is ignored.
- tok_cnt holds at 2^CNT_W-1 once reached.
- Reset mid-operation: the pending token is dropped and all state clears. Since out_A returns to 0 and the sender re-initializes in_R=0, the phases realign.

Test Plan:
- Reset: rst high 3 cycles with in_R=0 -> out_A=0, m_valid=0, level=0, tok_cnt=0, stall=0.
- Single token: toggle in_R 0->1 with in_data=8'hA5, m_ready=0 -> out_A goes 1 exactly 3 edges later; m_valid=1 and m_data=A5 next cycle; level=1, tok_cnt=1.
- Fill and stall:
  - Stimulus: 5 tokens 01..05, each sent after the prior out_A toggle, with m_ready=0.
  - Response: 4 acks; level=4; 5th token gives stall=1 and out_A holds.
  - Then assert m_ready 1 cycle: m_data=01 popped, token 05 captured in that same cycle, out_A toggles, stall=0, level stays 4.
- Streaming: m_ready=1 continuously, 20 tokens 00..13 -> output order exactly 00..13; pointer wrap exercised at least twice; tok_cnt=20; level never exceeds 1.
- Simultaneous push/pop at level=2 -> level stays 2 and order is preserved.
- Saturation, with CNT_W=4: 18 tokens -> tok_cnt=15 from the 15th token on.
- Reset mid-pending: in_R toggled, rst asserted after 1 cycle -> no ack toggle, level=0; a new token after reset is accepted normally.

Source files
------------

// File: rtl/del_token_if.sv
// Bundle of the async request/ack pair and the clocked output stream of
// del_token_responder. The sender side uses master; the responder uses slave.
interface del_token_if #(
  parameter int DATA_W = 8
);
  // in_R/out_A: two-phase; each in_R toggle is one token, answered by one out_A toggle.
  // m_valid/m_ready: a beat transfers on a clk edge where both are high; m_valid
  // and m_data stay stable until that transfer; m_ready while m_valid=0 is ignored.
  logic              in_R;
  logic [DATA_W-1:0] in_data;
  logic              out_A;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output in_R, in_data, m_ready,
    input  out_A, m_valid, m_data
  );

  modport slave (
    input  in_R, in_data, m_ready,
    output out_A, m_valid, m_data
  );
endinterface

// File: rtl/del_token_responder.sv
// Clocked end of an async delay chain: synchronizes a two-phase request, buffers
// the bundled data in a FIFO, returns a two-phase ack and streams tokens out.
module del_token_responder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  del_token_if.slave               bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     stall,
  output logic [CNT_W-1:0]         tok_cnt,
  output logic                     state_dbg_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_next;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   stall_q, stall_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [CNT_W-1:0]       tok_cnt_q, tok_cnt_d;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign req_next = sync_q[SYNC_STAGES-2];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && bus.m_ready;

  // state_q always equals (req_s != ack_q): it is computed from the value req_s
  // is about to take and the ack value being written, so no cycle is lost.
  always_comb begin
    ack_d   = ack_q;
    push    = 1'b0;
    stall_d = 1'b0;
    state_d = state_q;
    if (state_q == PEND) begin
      if (!full || pop) begin
        push  = 1'b1;
        ack_d = ~ack_q;
      end else begin
        stall_d = 1'b1;
      end
    end
    state_d = (req_next != ack_d) ? PEND : IDLE;
  end

  assign wptr_d    = wptr_q + PW'(push);
  assign rptr_d    = rptr_q + PW'(pop);
  assign tok_cnt_d = (push && (tok_cnt_q != {CNT_W{1'b1}})) ? tok_cnt_q + CNT_W'(1) : tok_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      tok_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.in_R};
      state_q   <= state_d;
      ack_q     <= ack_d;
      stall_q   <= stall_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      tok_cnt_q <= tok_cnt_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.out_A   = ack_q;
  assign bus.m_valid = !empty;
  assign bus.m_data  = mem[rptr_q[AW-1:0]];
  assign level       = wptr_q - rptr_q;
  assign stall       = stall_q;
  assign tok_cnt     = tok_cnt_q;
  assign state_dbg_o = state_q;

  logic unused_req_s;
  assign unused_req_s = req_s;
endmodule
